// File: rtl/ifft_4pt.sv
// 4-point radix-2 inverse FFT with start/done handshake and 1/4 output scaling.
// Build option IFFT_ROUND_EN selects round-half-up halving instead of floor.
module ifft_4pt #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] X [0:3],
    output logic [WIDTH-1:0] F [0:3],
    output logic             done
);

    localparam int H = WIDTH / 2;

    typedef enum logic [1:0] {IDLE, S1, S2, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] xr [0:3];
    logic [WIDTH-1:0] t  [0:3];
    logic [WIDTH-1:0] t_next [0:3];
    logic [WIDTH-1:0] f_next [0:3];

    // (a +/- b) / 2 on one lane: sign-extend to H+1 bits, then drop the LSB.
    function automatic logic [H-1:0] half_op(input logic [H-1:0] a,
                                             input logic [H-1:0] b,
                                             input logic sub);
        logic [H:0] s;
        s = sub ? ({a[H-1], a} - {b[H-1], b}) : ({a[H-1], a} + {b[H-1], b});
`ifdef IFFT_ROUND_EN
        s = s + {{H{1'b0}}, 1'b1};
`endif
        return s[H:1];
    endfunction

    function automatic logic [WIDTH-1:0] cbfly(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic sub);
        return {half_op(a[WIDTH-1:H], b[WIDTH-1:H], sub),
                half_op(a[H-1:0],     b[H-1:0],     sub)};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = S1;
            S1:      state_next = S2;
            S2:      state_next = DONE;
            DONE:    if (start) state_next = S1;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    always_comb begin
        t_next[0] = cbfly(xr[0], xr[2], 1'b0);
        t_next[1] = cbfly(xr[0], xr[2], 1'b1);
        t_next[2] = cbfly(xr[1], xr[3], 1'b0);
        t_next[3] = cbfly(xr[1], xr[3], 1'b1);

        f_next[0] = cbfly(t[0], t[2], 1'b0);
        f_next[2] = cbfly(t[0], t[2], 1'b1);
        // Twiddle +j: j*t3 = (-t3.im, t3.re), folded into the lane add/sub choice.
        f_next[1] = {half_op(t[1][WIDTH-1:H], t[3][H-1:0],     1'b1),
                     half_op(t[1][H-1:0],     t[3][WIDTH-1:H], 1'b0)};
        f_next[3] = {half_op(t[1][WIDTH-1:H], t[3][H-1:0],     1'b0),
                     half_op(t[1][H-1:0],     t[3][WIDTH-1:H], 1'b1)};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                xr[i] <= '0;
                t[i]  <= '0;
                F[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: if (start) xr <= X;
                S1:         t <= t_next;
                S2:         F <= f_next;
                default:    ;
            endcase
        end
    end

endmodule
